// File: rtl/montgomery_pipe_if.sv
// Handshake/bus bundle for montgomery_pipe.
//   slave  : reducer side (consumes transactions, produces results)
//   master : client side (issues transactions, accepts results)
// Input channel : in_valid_i/in_ready_o, x_i, m_i, minv_i, m_bl_i, tag_i
// Output channel: out_valid_o/out_ready_i, result_o, tag_o, err_o
interface montgomery_pipe_if #(
    parameter int unsigned DATA_LENGTH = 64,
    parameter int unsigned TAG_W       = 4
);
    localparam int unsigned MBW = $clog2(DATA_LENGTH + 1);

    logic                       in_valid_i;
    logic                       in_ready_o;
    logic [2*DATA_LENGTH-1:0]   x_i;
    logic [DATA_LENGTH-1:0]     m_i;
    logic [DATA_LENGTH-1:0]     minv_i;
    logic [MBW-1:0]             m_bl_i;
    logic [TAG_W-1:0]           tag_i;
    logic                       out_valid_o;
    logic                       out_ready_i;
    logic [DATA_LENGTH-1:0]     result_o;
    logic [TAG_W-1:0]           tag_o;
    logic                       err_o;

    modport slave (
        input  in_valid_i, x_i, m_i, minv_i, m_bl_i, tag_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o, tag_o, err_o
    );

    modport master (
        output in_valid_i, x_i, m_i, minv_i, m_bl_i, tag_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o, tag_o, err_o
    );
endinterface

// File: rtl/montgomery_pipe.sv
// Four-stage pipelined Montgomery reduction: result = x * 2^-m_bl mod m.
// Every operand travels with its transaction, so the modulus may change
// on every cycle. Illegal m_bl (0 or > DATA_LENGTH) flows through with err=1.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : montgomery_pipe_if slave (input and output valid/ready channels)
module montgomery_pipe #(
    parameter int unsigned DATA_LENGTH = 64,
    parameter int unsigned TAG_W       = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    montgomery_pipe_if.slave    bus
);
    localparam int unsigned DW  = DATA_LENGTH;
    localparam int unsigned DW2 = 2 * DATA_LENGTH;
    localparam int unsigned SW  = DATA_LENGTH + 1;
    localparam int unsigned MBW = $clog2(DATA_LENGTH + 1);

    // stage valids and handshake chain
    logic v1, v2, v3, v4;
    logic adv1_c, adv2_c, adv3_c, adv4_c;

    // stage payloads
    logic [TAG_W-1:0] tag1, tag2, tag3, tag4;
    logic             err1, err2, err3, err4;
    logic [DW2-1:0]   x1, x2;
    logic [DW-1:0]    m1, m2, m3;
    logic [MBW-1:0]   mbl1, mbl2;
    logic [DW-1:0]    q1;
    logic [DW2-1:0]   t2;
    logic [SW-1:0]    s3;
    logic [DW-1:0]    res4;

    // combinational stage logic
    logic [DW-1:0]    mask_c, lo_c, q_c;
    logic             err_c;
    logic [DW2-1:0]   t_c;
    logic [DW2:0]     sum_c;
    logic [SW-1:0]    s_c;
    logic [DW-1:0]    res_c;

    // A stage moves when it is empty or its successor moves; bubbles collapse.
    assign adv4_c = !v4 || bus.out_ready_i;
    assign adv3_c = !v3 || adv4_c;
    assign adv2_c = !v2 || adv3_c;
    assign adv1_c = !v1 || adv2_c;

    assign bus.in_ready_o  = adv1_c;
    assign bus.out_valid_o = v4;
    assign bus.result_o    = res4;
    assign bus.tag_o       = tag4;
    assign bus.err_o       = err4;

    // S1: R-1 mask built bitwise so m_bl == DATA_LENGTH never shifts by the full width
    always_comb begin
        mask_c = '0;
        for (int i = 0; i < DW; i++) begin
            mask_c[i] = (MBW'(i) < bus.m_bl_i);
        end
        lo_c  = bus.x_i[DW-1:0] & mask_c;
        q_c   = DW'(lo_c * bus.minv_i) & mask_c;
        err_c = (bus.m_bl_i == '0) || (bus.m_bl_i > MBW'(DW));
    end

    // S2: t = q*m at full double width
    assign t_c = DW2'(q1) * DW2'(m1);

    // S3: one extra bit keeps the carry of x + t before the shift
    assign sum_c = {1'b0, x2} + {1'b0, t2};
    assign s_c   = SW'(sum_c >> mbl2);

    // S4: final conditional subtract; error transactions report zero
    always_comb begin
        res_c = DW'(s3);
        if (err3) begin
            res_c = '0;
        end else if (s3 >= {1'b0, m3}) begin
            res_c = DW'(s3 - {1'b0, m3});
        end
    end

    // valid chain and visible output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            v3   <= 1'b0;
            v4   <= 1'b0;
            tag4 <= '0;
            err4 <= 1'b0;
            res4 <= '0;
        end else begin
            if (adv1_c) v1 <= bus.in_valid_i;
            if (adv2_c) v2 <= v1;
            if (adv3_c) v3 <= v2;
            if (adv4_c) v4 <= v3;
            if (adv4_c && v3) begin
                tag4 <= tag3;
                err4 <= err3;
                res4 <= res_c;
            end
        end
    end

    // datapath registers, only loaded when a valid transaction moves in
    always_ff @(posedge clk_i) begin
        if (adv1_c && bus.in_valid_i) begin
            tag1 <= bus.tag_i;
            err1 <= err_c;
            x1   <= bus.x_i;
            m1   <= bus.m_i;
            mbl1 <= bus.m_bl_i;
            q1   <= q_c;
        end
        if (adv2_c && v1) begin
            tag2 <= tag1;
            err2 <= err1;
            x2   <= x1;
            m2   <= m1;
            mbl2 <= mbl1;
            t2   <= t_c;
        end
        if (adv3_c && v2) begin
            tag3 <= tag2;
            err3 <= err2;
            m3   <= m2;
            s3   <= s_c;
        end
    end
endmodule

// File: tb/tb_montgomery_pipe.sv
// Directed bench for montgomery_pipe: fixed vectors for small moduli,
// boundary m_bl = 64 cases, illegal m_bl, stall/backpressure, a long
// stream against a residue model, and reset while busy.
module tb_montgomery_pipe;
    localparam int unsigned DL = 64;
    localparam int unsigned TW = 4;
    localparam logic [63:0] MBIG = 64'hFFFF_FFFF_FFFF_FFC5; // 2^64 - 59

    typedef struct {
        logic [63:0]  res;
        logic [3:0]   tag;
        logic         err;
        bit           resid;
        logic [127:0] x;
        logic [63:0]  m;
        bit           lat;
        int           in_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    montgomery_pipe_if #(.DATA_LENGTH(DL), .TAG_W(TW)) bus ();
    montgomery_pipe #(.DATA_LENGTH(DL), .TAG_W(TW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   n_out  = 0;
    int   n_exp  = 0;
    bit   stall     = 1'b0;
    bit   rnd_stall = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // -m^-1 mod 2^64 by Newton iteration (m odd)
    function automatic logic [63:0] neg_inv(input logic [63:0] m);
        logic [63:0] inv;
        inv = m;
        for (int i = 0; i < 6; i++) inv = inv * (64'd2 - m * inv);
        return 64'd0 - inv;
    endfunction

    // output monitor: checks the head of the queue whenever a result is shown
    initial begin
        exp_t e;
        bus.out_ready_i = 1'b1;
        forever begin
            @(negedge clk);
            bus.out_ready_i = rnd_stall ? ($urandom_range(0, 3) != 0) : !stall;
            #2;
            if (rst_n && bus.out_valid_o === 1'b1) begin
                if (q.size() == 0) begin
                    check("unexpected_out", 128'd1, 128'd0);
                end else begin
                    e = q[0];
                    check("tag", 128'(bus.tag_o), 128'(e.tag));
                    check("err", 128'(bus.err_o), 128'(e.err));
                    if (e.resid) begin
                        check("residue", (128'(bus.result_o) << 64) % 128'(e.m), e.x % 128'(e.m));
                        check("lt_m", 128'(bus.result_o < e.m), 128'd1);
                    end else begin
                        check("result", 128'(bus.result_o), 128'(e.res));
                    end
                    if (bus.out_ready_i) begin
                        void'(q.pop_front());
                        n_out++;
                        if (e.lat) check("latency", 128'(cyc + 1 - e.in_cyc), 128'd4);
                    end
                end
            end
        end
    end

    task automatic send(input logic [127:0] x, input logic [63:0] m, input logic [63:0] minv,
                        input logic [6:0] mbl, input logic [3:0] tag, input logic [63:0] res,
                        input logic err, input bit resid, input bit lat);
        exp_t e;
        int   n;
        @(negedge clk);
        bus.in_valid_i = 1'b1;
        bus.x_i    = x;
        bus.m_i    = m;
        bus.minv_i = minv;
        bus.m_bl_i = mbl;
        bus.tag_i  = tag;
        #1;
        n = 0;
        while (bus.in_ready_o !== 1'b1) begin
            if (n > 1000) begin
                check("in_ready_timeout", 128'd0, 128'd1);
                bus.in_valid_i = 1'b0;
                return;
            end
            n++;
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
        e.res = res; e.tag = tag; e.err = err; e.resid = resid;
        e.x = x; e.m = m; e.lat = lat; e.in_cyc = cyc;
        q.push_back(e);
        n_exp++;
    endtask

    // m = 17, R = 32, minv = 15
    task automatic s17(input logic [127:0] x, input logic [3:0] tag, input logic [63:0] res, input bit lat);
        send(x, 64'd17, 64'd15, 7'd5, tag, res, 1'b0, 1'b0, lat);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 20000) begin
            @(posedge clk);
            n++;
        end
        check("drain", 128'(q.size()), 128'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0]  minv_big;
        logic [127:0] x, lim;
        bus.in_valid_i = 1'b0;
        bus.x_i = '0; bus.m_i = '0; bus.minv_i = '0; bus.m_bl_i = '0; bus.tag_i = '0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 128'(bus.out_valid_o), 128'd0);
        check("rst_result", 128'(bus.result_o), 128'd0);
        check("rst_tag", 128'(bus.tag_o), 128'd0);
        check("rst_err", 128'(bus.err_o), 128'd0);
        check("rst_in_ready", 128'(bus.in_ready_o), 128'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("in_ready_after_rst", 128'(bus.in_ready_o), 128'd1);

        // single transaction and back-to-back stream
        s17(128'd100, 4'd3, 64'd1, 1'b1);
        drain();
        s17(128'd0, 4'd1, 64'd0, 1'b1);
        s17(128'd543, 4'd2, 64'd9, 1'b1);
        s17(128'd100, 4'd4, 64'd1, 1'b1);
        drain();

        // modulus changes every cycle: m = 13, R = 16, minv = 11
        s17(128'd100, 4'd9, 64'd1, 1'b1);
        send(128'd50, 64'd13, 64'd11, 7'd4, 4'd8, 64'd8, 1'b0, 1'b0, 1'b1);
        s17(128'd543, 4'd10, 64'd9, 1'b1);
        drain();

        // m_bl = DATA_LENGTH boundary
        minv_big = neg_inv(MBIG);
        send(128'd0, MBIG, minv_big, 7'd64, 4'd1, 64'd0, 1'b0, 1'b0, 1'b1);
        send(128'(MBIG), MBIG, minv_big, 7'd64, 4'd2, 64'd0, 1'b0, 1'b0, 1'b1);
        send({64'd1, 64'd0}, MBIG, minv_big, 7'd64, 4'd3, 64'd1, 1'b0, 1'b0, 1'b1);
        send({64'd5, 64'd0}, MBIG, minv_big, 7'd64, 4'd4, 64'd5, 1'b0, 1'b0, 1'b1);
        drain();

        // backpressure: x = 32*k reduces to k mod 17
        fork
            for (int k = 0; k < 10; k++)
                s17(128'(32 * (k + 5)), 4'(k), 64'((k + 5) % 17), 1'b0);
            begin
                repeat (3) @(posedge clk);
                #1 stall = 1'b1;
                repeat (6) @(posedge clk);
                #1;
                check("in_ready_full", 128'(bus.in_ready_o), 128'd0);
                check("out_valid_held", 128'(bus.out_valid_o), 128'd1);
                stall = 1'b0;
            end
        join
        drain();

        // illegal m_bl, then a legal transaction
        send(128'd100, 64'd17, 64'd15, 7'd0, 4'd5, 64'd0, 1'b1, 1'b0, 1'b1);
        send(128'd100, 64'd17, 64'd15, 7'd65, 4'd6, 64'd0, 1'b1, 1'b0, 1'b1);
        s17(128'd100, 4'd7, 64'd1, 1'b1);
        drain();

        // long stream with random backpressure against the residue model
        rnd_stall = 1'b1;
        lim = {MBIG, 64'd0};
        for (int i = 0; i < 10000; i++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            if (x >= lim) x = x - lim;
            send(x, MBIG, minv_big, 7'd64, 4'(i), 64'd0, 1'b0, 1'b1, 1'b0);
        end
        send(lim - 128'd1, MBIG, minv_big, 7'd64, 4'd15, 64'd0, 1'b0, 1'b1, 1'b0);
        rnd_stall = 1'b0;
        drain();

        // reset with three transactions in flight
        s17(128'd100, 4'd1, 64'd1, 1'b0);
        s17(128'd543, 4'd2, 64'd9, 1'b0);
        s17(128'd0, 4'd3, 64'd0, 1'b0);
        @(posedge clk);
        #1;
        check("pre_reset_valid", 128'(bus.out_valid_o), 128'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 128'(bus.out_valid_o), 128'd0);
        check("async_rst_result", 128'(bus.result_o), 128'd0);
        check("async_rst_tag", 128'(bus.tag_o), 128'd0);
        check("async_rst_err", 128'(bus.err_o), 128'd0);
        check("rst_in_ready_busy", 128'(bus.in_ready_o), 128'd1);
        n_exp = n_exp - q.size();
        q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("in_ready_release", 128'(bus.in_ready_o), 128'd1);
        repeat (8) @(posedge clk);
        s17(128'd100, 4'd11, 64'd1, 1'b1);
        drain();

        check("delivered_count", 128'(n_out), 128'(n_exp));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
